// File: rtl/fifomult_operand_rx.sv
// Receive side of the fifomult2024 serial operand link.
// Words arrive one per handshake and are parity checked. Consecutive words
// are paired as operand A then operand B. The pairs are queued in a small
// show-ahead FIFO and handed to the multiplier core over valid/ready. busy_out
// throttles the sender while the FIFO is full.
module fifomult_operand_rx #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     data_in_parity,
  input  logic                     data_in_valid,
  output logic                     busy_out,
  output logic                     pair_valid,
  input  logic                     pair_ready,
  output logic [DATA_W-1:0]        pair_a,
  output logic [DATA_W-1:0]        pair_b,
  output logic                     pair_parity_err,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overrun_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic {
    PH_A,
    PH_B
  } phase_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              err;
  } pair_t;

  phase_e            phase_q;
  logic [DATA_W-1:0] a_hold_q;
  logic              a_err_q;

  pair_t             mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic [LW-1:0]     level_d;
  logic              busy_q;
  logic              overrun_q;

  logic              accept;
  logic              word_err;
  logic              push;
  logic              pop;
  pair_t             head;

  // A word is taken only while the sender is not being held off. An A word
  // never touches the FIFO, so only B accepts count as pushes.
  assign accept   = data_in_valid & ~busy_q;
  assign word_err = ((^data_in) != data_in_parity);
  assign push     = accept & (phase_q == PH_B);
  assign pop      = pair_valid & pair_ready;

  // Occupancy after this edge. busy_out is registered from this value, so it
  // rises together with the push that fills the FIFO.
  always_comb begin
    // NOTE: default assignment first so no path leaves level_d unassigned (no latch).
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  // Phase FSM: hold operand A until its partner B arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PH_A;
      a_hold_q <= '0;
      a_err_q  <= 1'b0;
    end else if (accept) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      unique case (phase_q)
        PH_A: begin
          a_hold_q <= data_in;
          a_err_q  <= word_err;
          phase_q  <= PH_B;
        end
        PH_B: begin
          phase_q  <= PH_A;
        end
        default: phase_q <= PH_A;
      endcase
    end
  end

  // Pair storage. The write is gated by push, so it never lands on an
  // occupied slot.
  // NOTE: storage has no reset; stale entries stay hidden because pair_valid is 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{a: a_hold_q, b: data_in, err: a_err_q | word_err};
    end
  end

  // Pointers, occupancy, back-pressure and the sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      level_q <= level_d;
      busy_q  <= (level_d == LW'(DEPTH));
      if (data_in_valid && busy_q) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Show-ahead head. Data is forced to zero while empty so that the outputs
  // read as zero after reset, whatever the storage holds.
  assign head            = mem_q[rd_ptr_q];
  assign pair_valid      = (level_q != '0);
  assign pair_a          = pair_valid ? head.a : '0;
  assign pair_b          = pair_valid ? head.b : '0;
  assign pair_parity_err = pair_valid & head.err;
  assign level           = level_q;
  assign busy_out        = busy_q;
  assign overrun_err     = overrun_q;

endmodule
